// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// with an early exit for divide-by-zero and signed-overflow cases.
//   state  | meaning
//   IDLE   | ready for a new operation
//   BUSY   | WIDTH shift/add or shift/subtract iterations
//   DONE   | result presented (valid_o) for one cycle
module ex_muldiv_unit #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_FWD = 2,
    localparam int SELW    = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     flush_i,
    input  logic [2:0]               op_i,
    input  logic [WIDTH-1:0]         rs1_data_i,
    input  logic [WIDTH-1:0]         rs2_data_i,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data_i,
    input  logic [SELW-1:0]          fwdA_sel_i,
    input  logic [SELW-1:0]          fwdB_sel_i,
    input  logic [4:0]               rd_i,
    output logic [4:0]               rd_o,
    output logic                     ready_o,
    output logic                     busy_o,
    output logic                     stall_o,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         result_o
);

    localparam int CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [WIDTH-1:0]  r_m;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_result;
    logic              r_neg;
    logic              r_negr;

    logic [WIDTH-1:0]  w_opa, w_opb;
    logic              w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [WIDTH-1:0]  w_mag_a, w_mag_b;
    logic              w_div0, w_ovf;
    logic [WIDTH-1:0]  w_early_res;

    logic [WIDTH:0]    w_shift, w_sum;
    logic [WIDTH-1:0]  w_diff, w_nhi, w_nlo;
    logic              w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]  w_quo, w_rem, w_final;

    always_comb begin
        w_opa = rs1_data_i;
        w_opb = rs2_data_i;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwdA_sel_i == SELW'(k)) w_opa = fwd_data_i[(k-1)*WIDTH +: WIDTH];
            if (fwdB_sel_i == SELW'(k)) w_opb = fwd_data_i[(k-1)*WIDTH +: WIDTH];
        end
    end

    // Signed ops run on magnitudes; the sign is reapplied on completion.
    always_comb begin
        w_is_div    = op_i[2];
        w_a_signed  = (op_i == 3'd1) | (op_i == 3'd2) | (op_i[2] & ~op_i[0]);
        w_b_signed  = (op_i == 3'd1) | (op_i[2] & ~op_i[0]);
        w_sa        = w_a_signed & w_opa[WIDTH-1];
        w_sb        = w_b_signed & w_opb[WIDTH-1];
        w_mag_a     = w_sa ? -w_opa : w_opa;
        w_mag_b     = w_sb ? -w_opb : w_opb;
        w_div0      = w_is_div & (w_opb == '0);
        w_ovf       = w_is_div & ~op_i[0] & (w_opa == {1'b1, {(WIDTH-1){1'b0}}}) & (w_opb == '1);
        w_early_res = w_div0 ? (op_i[1] ? w_opa : '1) : (op_i[1] ? '0 : w_opa);
    end

    always_comb begin
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_m});
        w_diff  = w_shift[WIDTH-1:0] - r_m;
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        if (r_op[2]) begin
            w_nhi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            w_nlo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_nhi = w_sum[WIDTH:1];
            w_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
        w_prod = {w_nhi, w_nlo};
        if (r_neg) w_prod = -w_prod;
        w_quo = r_neg  ? -w_nlo : w_nlo;
        w_rem = r_negr ? -w_nhi : w_nhi;
        if (r_op[2])
            w_final = r_op[1] ? w_rem : w_quo;
        else
            w_final = (r_op[1:0] == 2'd0) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_negr   <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_op   <= op_i;
                        r_rd   <= rd_i;
                        r_neg  <= w_sa ^ w_sb;
                        r_negr <= w_sa;
                        r_hi   <= '0;
                        r_cnt  <= '0;
                        r_m    <= w_is_div ? w_mag_b : w_mag_a;
                        r_lo   <= w_is_div ? w_mag_a : w_mag_b;
                        if (w_div0 | w_ovf) begin
                            r_result <= w_early_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi <= w_nhi;
                    r_lo <= w_nlo;
                    if (r_cnt == CNTW'(WIDTH - 1)) begin
                        r_cnt    <= '0;
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A flush arriving in DONE suppresses the result in that same cycle.
    always_comb begin
        ready_o  = (r_state == S_IDLE);
        busy_o   = (r_state == S_BUSY);
        valid_o  = (r_state == S_DONE) & ~flush_i;
        stall_o  = busy_o | (start_i & ready_o) | ((r_state == S_DONE) & ~valid_o);
        result_o = r_result;
        rd_o     = r_rd;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits (>= 8, even).
REQ-002 SHALL have parameter NUM_FWD, default 2: number of forwarding sources (>= 1).
REQ-003 SHALL define SELW = clog2(NUM_FWD+1) as a derived localparam.
REQ-004 SHALL provide clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL provide start_i  input  1  request to begin an operation.
REQ-007 SHALL provide flush_i  input  1  abort any in-flight operation.
REQ-008 SHALL provide op_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL provide rs1_data_i, rs2_data_i  input  WIDTH  operands from the ID/EX register.
REQ-010 SHALL provide fwd_data_i  input  NUM_FWD*WIDTH  forwarded values; source k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL provide fwdA_sel_i, fwdB_sel_i  input  SELW  0 selects the rs operand; k in 1..NUM_FWD selects source k-1.
REQ-012 SHALL provide rd_i  input  5 and rd_o  output  5  destination register, captured at accept.
REQ-013 SHALL provide ready_o, busy_o, stall_o, valid_o  output  1 each, and result_o  output  WIDTH.

Function
REQ-014 SHALL resolve operand A/B combinationally from the select inputs; an out-of-range select (> NUM_FWD) SHALL pick the rs operand.
REQ-015 SHALL implement states IDLE, BUSY, DONE; ready_o = (state == IDLE), busy_o = (state == BUSY).
REQ-016 SHALL accept an operation when start_i and ready_o are both high, latching resolved operands, op_i and rd_i in that cycle.
REQ-017 SHALL ignore start_i in BUSY and DONE (no re-latch, no queueing).
REQ-018 SHALL drive stall_o = busy_o OR (start_i AND ready_o) OR (state == DONE AND NOT valid_o), so upstream holds until the result is presented.
REQ-019 SHALL perform normal operations iteratively at one bit per cycle: IDLE -> BUSY on accept, BUSY for exactly WIDTH cycles (counter 0..WIDTH-1), then DONE.
REQ-020 SHALL assert valid_o for exactly one cycle in DONE, then return to IDLE; accept at cycle 0 gives valid_o at cycle WIDTH+1.
REQ-021 SHALL compute signed ops on magnitudes and negate at the end: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A); MULHSU treats A as signed and B as unsigned.
REQ-022 SHALL return bits [WIDTH-1:0] of the 2*WIDTH product for MUL and bits [2*WIDTH-1:WIDTH] for MULH/MULHSU/MULHU.
REQ-023 SHALL handle divide-by-zero with a go-straight-to-DONE path: DIV/DIVU quotient all ones, REM/REMU = A; valid_o at cycle 1.
REQ-024 SHALL handle signed overflow (A = most negative, B = -1) with the same early path: DIV = A, REM = 0; valid_o at cycle 1.
REQ-025 SHALL hold result_o and rd_o stable from valid_o until the next accept; their value outside valid_o is don't-care for consumers.
REQ-026 SHALL, on flush_i in any state, go to IDLE on the next edge without asserting valid_o; flush_i has priority over start_i and completion in the same cycle.
REQ-027 SHALL give flush_i during DONE precedence over valid_o: valid_o is forced low in that cycle.

Reset
REQ-028 SHALL on rst enter IDLE, clear the iteration counter, and drive valid_o = 0, busy_o = 0, result_o = 0, rd_o = 0.
REQ-029 SHALL give rst priority over flush_i and start_i; reset mid-operation discards it with no valid_o.

Verification (WIDTH=32, NUM_FWD=2)
REQ-030 SHALL test MUL, A=7, B=0xFFFFFFFD -> result_o 0xFFFFFFEB, valid_o at cycle 33, stall_o high cycles 0-32.
REQ-031 SHALL test MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL test DIVU 13/0 -> 0xFFFFFFFF and REMU 13/0 -> 13; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; all with valid_o at cycle 1.
REQ-033 SHALL test forwarding: fwdA_sel=2 with source 1 = 0x10, fwdB_sel=0 with rs2=3; DIVU -> 5, REMU -> 1; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-034 SHALL test abort: flush_i at cycle 10 of a DIV -> no valid_o, ready_o at cycle 11, new start accepted at cycle 11 completes correctly.
REQ-035 SHALL test rst at cycle 5 of a MUL -> IDLE next edge, no valid_o, all outputs zero; start_i during BUSY -> latched operands unchanged.
